// File: rtl/count_disp_pkg.sv
// Shared constants for the count display: active-low glyphs, glyph codes and scan slot indices.
package count_disp_pkg;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_U     = 7'h41;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Glyph codes above the decimal digits
  localparam logic [3:0] CODE_U     = 4'd10;
  localparam logic [3:0] CODE_D     = 4'd11;
  localparam logic [3:0] CODE_BLANK = 4'd15;

  localparam int unsigned IDX_W = 2;
  localparam logic [IDX_W-1:0] IDX_ONES  = 2'd0;
  localparam logic [IDX_W-1:0] IDX_TENS  = 2'd1;
  localparam logic [IDX_W-1:0] IDX_BLANK = 2'd2;
  localparam logic [IDX_W-1:0] IDX_DIR   = 2'd3;

endpackage

// File: rtl/seg7_glyph.sv
// Combinational glyph code to active-low 7-segment pattern; unknown codes render blank.
module seg7_glyph
  import count_disp_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] glyph
);

  always_comb begin
    glyph = SEG_BLANK;
    case (code)
      4'd0:    glyph = SEG_0;
      4'd1:    glyph = SEG_1;
      4'd2:    glyph = SEG_2;
      4'd3:    glyph = SEG_3;
      4'd4:    glyph = SEG_4;
      4'd5:    glyph = SEG_5;
      4'd6:    glyph = SEG_6;
      4'd7:    glyph = SEG_7;
      4'd8:    glyph = SEG_8;
      4'd9:    glyph = SEG_9;
      CODE_U:  glyph = SEG_U;
      CODE_D:  glyph = SEG_D;
      default: glyph = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/count_display_mux.sv
// Scans a 0..15 count plus direction glyph onto a 4-digit multiplexed 7-segment display,
// latching the inputs once per frame and blanking all anodes at the start of each slot.
module count_display_mux
  import count_disp_pkg::*;
#(
  parameter int unsigned DIGIT_CYCLES   = 50000,
  parameter int unsigned BLANK_CYCLES   = 16,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] count,
  input  logic       up_down,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       frame_tick
);

  localparam int unsigned TICK_W = $clog2(DIGIT_CYCLES);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIGIT_CYCLES - 1);
  localparam logic [TICK_W-1:0] BLANK_END = TICK_W'(BLANK_CYCLES);
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? SEG_BLANK : ~SEG_BLANK;
  localparam logic [3:0] AN_OFF  = AN_ACTIVE_LOW ? 4'hF : 4'h0;

  logic [TICK_W-1:0] tick_q;
  logic [IDX_W-1:0]  idx_q;
  logic [3:0]        snap_count_q;
  logic              snap_dir_q;
  logic [6:0]        seg_q;
  logic [3:0]        an_q;

  logic       slot_end, snap_now, blanking;
  logic [3:0] code;
  logic [6:0] glyph;
  logic [6:0] seg_d;
  logic [3:0] an_d;

  assign slot_end = (tick_q == TICK_LAST);
  assign snap_now = slot_end && (idx_q == IDX_DIR);
  assign blanking = (tick_q < BLANK_END);

  always_comb begin
    code = CODE_BLANK;
    case (idx_q)
      IDX_ONES:  code = (snap_count_q >= 4'd10) ? snap_count_q - 4'd10 : snap_count_q;
      IDX_TENS:  code = (snap_count_q >= 4'd10) ? 4'd1 : CODE_BLANK;
      IDX_BLANK: code = CODE_BLANK;
      IDX_DIR:   code = snap_dir_q ? CODE_U : CODE_D;
      default:   code = CODE_BLANK;
    endcase
  end

  seg7_glyph u_glyph (
    .code  (code),
    .glyph (glyph)
  );

  // Build active-low patterns first, then flip for the configured board polarity.
  always_comb begin
    seg_d = blanking ? SEG_BLANK : glyph;
    an_d  = blanking ? 4'hF : ~(4'b0001 << idx_q);
    if (!SEG_ACTIVE_LOW) seg_d = ~seg_d;
    if (!AN_ACTIVE_LOW)  an_d  = ~an_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q       <= '0;
      idx_q        <= IDX_ONES;
      snap_count_q <= 4'd0;
      snap_dir_q   <= 1'b1;
      seg_q        <= SEG_OFF;
      an_q         <= AN_OFF;
    end else begin
      tick_q <= slot_end ? '0 : tick_q + 1'b1;
      if (slot_end) idx_q <= idx_q + 1'b1;
      if (snap_now) begin
        snap_count_q <= count;
        snap_dir_q   <= up_down;
      end
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign dp         = SEG_ACTIVE_LOW;
  assign frame_tick = snap_now;

endmodule

// File: tb/tb_count_display_mux.sv
// Self-checking bench for count_display_mux: per-frame vector table plus hand sequences for
// mid-frame input changes and mid-frame reset, checked through a time-stamped scoreboard.
module tb_count_display_mux;

  logic       clk;
  logic       reset;
  logic [3:0] count;
  logic       up_down;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       frame_tick;

  count_display_mux #(
    .DIGIT_CYCLES   (8),
    .BLANK_CYCLES   (2),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .count      (count),
    .up_down    (up_down),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_tick (frame_tick)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  typedef struct {
    int         at;
    logic [3:0] an;
    logic [6:0] seg;
    logic       ft;
  } exp_t;

  typedef struct {
    logic [3:0] count;
    logic       dir;
    logic [6:0] s0;
    logic [6:0] s1;
    logic [6:0] s3;
  } vec_t;

  exp_t sb_q[$];
  exp_t mon_e;
  vec_t vecs[6];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   ft_cnt = 0;

  // Edges since the last reset edge: after edge e the DUT outputs reflect state e-1.
  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, got, want);
    end
  endtask

  task automatic wait_edge(input int e);
    int g = 0;
    while (cyc < e && g < 2000) begin
      @(posedge clk);
      #1;
      g++;
    end
    checks++;
    if (cyc < e) begin
      failures++;
      $display("FAIL wait_edge timeout: cyc %0d expected %0d", cyc, e);
    end
  endtask

  // Expected outputs after edge e, for a frame whose digits show s0/s1/s3.
  function automatic exp_t exp_at(input int e, input logic [6:0] s0, input logic [6:0] s1,
                                   input logic [6:0] s3);
    exp_t r;
    int t = (e - 1) % 8;
    int i = ((e - 1) / 8) % 4;
    r.at = e;
    r.ft = (e % 32 == 31);
    if (t < 2) begin
      r.an  = 4'hF;
      r.seg = 7'h7F;
    end else begin
      r.an = 4'hF;
      r.an[i] = 1'b0;
      case (i)
        0:       r.seg = s0;
        1:       r.seg = s1;
        3:       r.seg = s3;
        default: r.seg = 7'h7F;
      endcase
    end
    return r;
  endfunction

  task automatic push_frame(input int f, input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s3);
    int offs[9] = '{1, 2, 3, 11, 17, 19, 27, 31, 32};
    foreach (offs[j]) sb_q.push_back(exp_at(f + offs[j], s0, s1, s3));
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      while (sb_q.size() > 0 && sb_q[0].at <= cyc) begin
        mon_e = sb_q.pop_front();
        if (mon_e.at < cyc) begin
          chk("sb_missed", 32'(cyc), 32'(mon_e.at));
        end else begin
          chk("an", 32'(an), 32'(mon_e.an));
          chk("seg", 32'(seg), 32'(mon_e.seg));
          chk("frame_tick", 32'(frame_tick), 32'(mon_e.ft));
          chk("dp", 32'(dp), 32'h1);
        end
      end
      if (cyc >= 225 && cyc <= 288 && frame_tick === 1'b1) ft_cnt++;
    end
  end

  initial begin
    vecs[0] = '{4'd7,  1'b1, 7'h78, 7'h7F, 7'h41};
    vecs[1] = '{4'd12, 1'b1, 7'h24, 7'h79, 7'h41};
    vecs[2] = '{4'd15, 1'b0, 7'h12, 7'h79, 7'h21};
    vecs[3] = '{4'd0,  1'b1, 7'h40, 7'h7F, 7'h41};
    vecs[4] = '{4'd9,  1'b0, 7'h10, 7'h7F, 7'h21};
    vecs[5] = '{4'd10, 1'b1, 7'h40, 7'h79, 7'h41};

    reset   = 1'b1;
    count   = 4'd5;
    up_down = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'h1);
    chk("rst_ft", 32'(frame_tick), 32'h0);
    reset = 1'b0;
    // Snapshot cleared to 0/up, regardless of the live inputs.
    push_frame(0, 7'h40, 7'h7F, 7'h41);

    for (int k = 0; k < 6; k++) begin
      wait_edge(32 * (k + 1) - 1);
      count   = vecs[k].count;
      up_down = vecs[k].dir;
      push_frame(32 * (k + 1), vecs[k].s0, vecs[k].s1, vecs[k].s3);
    end

    // Mid-frame input changes must not leak into the frame being shown.
    wait_edge(223);
    count   = 4'd3;
    up_down = 1'b1;
    push_frame(224, 7'h30, 7'h7F, 7'h41);
    wait_edge(234);
    count = 4'd9;
    wait_edge(244);
    up_down = 1'b0;
    wait_edge(255);
    push_frame(256, 7'h10, 7'h7F, 7'h21);
    wait_edge(289);
    chk("ft_per_64", 32'(ft_cnt), 32'd2);

    // Reset during idx2, tick 5.
    wait_edge(309);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_an", 32'(an), 32'hF);
    chk("midrst_seg", 32'(seg), 32'h7F);
    chk("midrst_ft", 32'(frame_tick), 32'h0);
    chk("midrst_sb_empty", 32'(sb_q.size()), 32'd0);
    reset = 1'b0;
    push_frame(0, 7'h40, 7'h7F, 7'h41);

    wait_edge(33);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
